// File: rtl/ring_rotator_pkg.sv
// ring_rotator_pkg: shared direction and mode encodings for the ring rotator
package ring_rotator_pkg;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;
  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;
endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: counts enabled cycles and ticks once every max(period,1)
module step_prescaler #(
  parameter int CNT_W = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pm;
  // >= rather than == so a lowered period fires at once instead of wrapping
  always_comb begin
    pm   = (period == '0) ? CNT_W'(1) : period;
    tick = en && !clr && (count >= pm - CNT_W'(1));
  end
  // count restarts on reset, load or a tick and freezes while en is low
  always_ff @(posedge clk) begin
    if (!rst_n || clr) count <= '0;
    else if (en) count <= tick ? '0 : count + CNT_W'(1);
  end
endmodule

// File: rtl/ring_rotator.sv
// ring_rotator: walking pattern with programmable period, direction, load and bounce
module ring_rotator
  import ring_rotator_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter int               CNT_W = 15,
  parameter logic [WIDTH-1:0] INIT  = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             step
);
  logic             tick;
  logic             bdir;
  logic             mode_q;
  logic             eb;
  logic             nb;
  logic             both;
  logic             hit;
  logic [WIDTH-1:0] nxt;
  step_prescaler #(.CNT_W(CNT_W)) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (load),
    .period(period),
    .tick  (tick)
  );
  // next pattern: rotate follows dir, bounce follows bdir and reflects off a set end bit
  always_comb begin
    eb   = (mode == MODE_BOUNCE && mode_q == MODE_ROTATE) ? dir : bdir;
    both = out[WIDTH-1] && out[0];
    hit  = (eb == DIR_DOWN) ? out[0] : out[WIDTH-1];
    nb   = (mode == MODE_BOUNCE && hit && !both) ? ~eb : eb;
    nxt  = (mode == MODE_ROTATE) ?
             ((dir == DIR_DOWN) ? {out[0], out[WIDTH-1:1]} : {out[WIDTH-2:0], out[WIDTH-1]}) :
           both ? out :
             ((nb == DIR_DOWN) ? {1'b0, out[WIDTH-1:1]} : {out[WIDTH-2:0], 1'b0});
  end
  // pattern, bounce direction and step pulse; reset beats load beats step
  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (!rst_n || load) begin
      out  <= !rst_n ? INIT : load_val;
      step <= 1'b0;
      bdir <= dir;
    end else begin
      step <= tick;
      bdir <= tick ? nb : eb;
      if (tick) out <= nxt;
    end
  end
endmodule
